fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the pipelined MIPS core.
- Owns the PC and drives the instruction-memory request with a hit handshake.
- Latches the fetched word and PC+4 into IF/ID; the decode stage splits that word into opcode/funct for the control unit.
- Honors stall from the hazard unit, flush/redirect from branch resolution, and halt from decode.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
ihit  input  1  instruction memory returns valid iload this cycle
iload  input  32  instruction word from memory
imemREN  output  1  instruction read request
imemaddr  output  32  instruction address (current PC)
stall  input  1  hazard unit: hold PC and IF/ID
flush  input  1  squash IF/ID contents to bubble
redirect  input  1  taken branch/jump/jr resolved; load redirect_pc
redirect_pc  input  32  target PC
halt  input  1  decode saw HALT opcode
ifid_instr  output  32  latched instruction (0 = NOP when bubble)
ifid_npc  output  32  latched PC+4 of that instruction
ifid_valid  output  1  IF/ID holds a real instruction
halted  output  1  stage in HALTED state

Behaviour:
- Reset (async, nRST=0):
  - pc=PC_INIT, state=FETCH.
  - ifid_instr=0, ifid_npc=0, ifid_valid=0, halted=0.
  - imemREN forced 0 while nRST=0.
- States:
  - FETCH: request outstanding.
  - HOLD: fetched word parked, FETCH_SKID_EN only.
  - HALTED: terminal until reset.
- Outputs:
  - imemaddr=pc always.
  - imemREN=1 in FETCH when !stall (without skid) or in FETCH regardless of stall (with skid); 0 in HOLD and HALTED.
- Per-cycle priority, highest first: redirect, halt, flush, stall, ihit advance.
- redirect=1 (any state except HALTED):
  - pc<=redirect_pc with bits [1:0] forced 0.
  - ifid_instr<=0, ifid_valid<=0.
  - Any same-cycle ihit is discarded; skid entry is discarded; state<=FETCH.
  - Overrides a same-cycle halt (halt was wrong-path).
- halt=1 (no redirect):
  - state<=HALTED, halted<=1.
  - pc frozen; IF/ID gets NOP with valid=0.
- flush=1 (no redirect/halt):
  - IF/ID <= NOP/valid 0 even if stall=1.
  - pc unchanged unless advancing per rules below.
- stall=1: pc, ifid_instr, ifid_npc, ifid_valid hold.
- FETCH && ihit && !stall:
  - ifid_instr<=iload, ifid_npc<=pc+4, ifid_valid<=1, pc<=pc+4.
  - Latency: 1 cycle from ihit to IF/ID.
- FETCH && !ihit && !stall: IF/ID <= NOP/valid 0 (bubble); pc holds.
- Arithmetic: pc+4 is 32-bit, wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- HALTED:
  - Ignores all inputs except nRST.
  - IF/ID holds the NOP.
- Reset mid-operation: immediate return to reset values; any in-flight ihit is dropped.

Optional Feature:
Macro FETCH_SKID_EN.
- Defined:
  - Fetch continues during stall.
  - FETCH && ihit && stall: iload and pc+4 go into a 1-entry skid buffer, pc<=pc+4, state<=HOLD.
  - In HOLD, when stall drops: IF/ID <= skid entry, valid 1, state<=FETCH.
  - redirect in HOLD clears skid.
  - flush in HOLD clears IF/ID only; skid retained.
- Undefined:
  - imemREN=0 while stall; ihit during stall is ignored.
  - No HOLD state.

Test Plan:
- Reset release, ihit=1 each cycle, iload=32'h2401_0005 then 32'h2402_0003 -> imemaddr 0,4,8; ifid_instr 32'h2401_0005 with ifid_npc 4, then 32'h2402_0003 with ifid_npc 8; valid=1.
- stall=1 for 3 cycles at pc=8 -> pc, ifid_* constant; imemREN=0 (no skid) or one skid capture then imemREN=0 in HOLD (skid); on release the next instr appears in 1 cycle.
- redirect=1, redirect_pc=32'h0000_0043, with simultaneous ihit and halt -> pc=32'h40, ifid_valid=0, halted stays 0.
- halt=1 -> halted=1 next cycle, imemREN=0, pc frozen; later redirect/ihit have no effect; nRST pulse -> pc=PC_INIT, halted=0.
- flush=1 with stall=1 -> ifid_instr=0, ifid_valid=0, pc held.
- pc=32'hFFFF_FFFC, ihit=1 -> pc=0, ifid_npc=0; assert nRST low mid-ihit -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with PC ownership and the IF/ID
// pipeline register. Drives an instruction-memory read request, advances on
// ihit, and honors redirect > halt > flush > stall in that order.
// Optional macro FETCH_SKID_EN: keep fetching during stall by parking one
// fetched word in a skid entry (HOLD state) until the stall releases.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid,
    output logic        halted
);

`ifdef FETCH_SKID_EN
    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_HOLD   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_HALTED = 2'd2
    } state_t;
`endif

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_instr;
    logic [31:0] w_instr_next;
    logic [31:0] r_npc;
    logic [31:0] w_npc_next;
    logic        r_valid;
    logic        w_valid_next;
    logic [31:0] w_pc_plus4;
`ifdef FETCH_SKID_EN
    logic [31:0] r_skid_instr;
    logic [31:0] w_skid_instr_next;
    logic [31:0] r_skid_npc;
    logic [31:0] w_skid_npc_next;
`endif

    // Low address bits of a redirect target are discarded (word alignment).
    logic w_unused;
    assign w_unused = &{1'b0, redirect_pc[1:0]};

    // Natural wrap at 32 bits is intended.
    assign w_pc_plus4 = r_pc + 32'd4;

    assign imemaddr   = r_pc;
    assign ifid_instr = r_instr;
    assign ifid_npc   = r_npc;
    assign ifid_valid = r_valid;
    assign halted     = (r_state == ST_HALTED);

`ifdef FETCH_SKID_EN
    assign imemREN = nRST && (r_state == ST_FETCH);
`else
    assign imemREN = nRST && (r_state == ST_FETCH) && !stall;
`endif

    // State and pipeline register; async reset drops any in-flight fetch.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= ST_FETCH;
            r_pc         <= PC_INIT;
            r_instr      <= 32'd0;
            r_npc        <= 32'd0;
            r_valid      <= 1'b0;
`ifdef FETCH_SKID_EN
            r_skid_instr <= 32'd0;
            r_skid_npc   <= 32'd0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_instr      <= w_instr_next;
            r_npc        <= w_npc_next;
            r_valid      <= w_valid_next;
`ifdef FETCH_SKID_EN
            r_skid_instr <= w_skid_instr_next;
            r_skid_npc   <= w_skid_npc_next;
`endif
        end
    end

    // Next-state / next-register logic in priority order redirect, halt, flush, stall, advance.
    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_instr_next      = r_instr;
        w_npc_next        = r_npc;
        w_valid_next      = r_valid;
`ifdef FETCH_SKID_EN
        w_skid_instr_next = r_skid_instr;
        w_skid_npc_next   = r_skid_npc;
`endif
        if (r_state != ST_HALTED) begin
            if (redirect) begin
                // Wrong-path work (fetch, skid, halt) is all discarded.
                w_pc_next    = {redirect_pc[31:2], 2'b00};
                w_instr_next = 32'd0;
                w_valid_next = 1'b0;
                w_state_next = ST_FETCH;
`ifdef FETCH_SKID_EN
                w_skid_instr_next = 32'd0;
                w_skid_npc_next   = 32'd0;
`endif
            end else if (halt) begin
                w_state_next = ST_HALTED;
                w_instr_next = 32'd0;
                w_valid_next = 1'b0;
            end else begin
                if (r_state == ST_FETCH) begin
                    if (!stall) begin
                        if (ihit) begin
                            w_instr_next = iload;
                            w_npc_next   = w_pc_plus4;
                            w_valid_next = 1'b1;
                            w_pc_next    = w_pc_plus4;
                        end else begin
                            w_instr_next = 32'd0;
                            w_valid_next = 1'b0;
                        end
                    end
`ifdef FETCH_SKID_EN
                    else if (ihit) begin
                        // Decode is stalled: park the word and keep the PC moving.
                        w_skid_instr_next = iload;
                        w_skid_npc_next   = w_pc_plus4;
                        w_pc_next         = w_pc_plus4;
                        w_state_next      = ST_HOLD;
                    end
`endif
                end
`ifdef FETCH_SKID_EN
                else if (!stall && !flush) begin
                    // Stall released: hand the parked word to decode.
                    w_instr_next = r_skid_instr;
                    w_npc_next   = r_skid_npc;
                    w_valid_next = 1'b1;
                    w_state_next = ST_FETCH;
                end
`endif
                // Flush squashes IF/ID even under stall; PC/skid progress is kept.
                if (flush) begin
                    w_instr_next = 32'd0;
                    w_valid_next = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test-plan sequence followed by randomized
// stimulus, checked every cycle against a rule-level behavioural model.
module tb_fetch_stage;

`ifdef FETCH_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit = 1'b0;
    logic [31:0] iload = 32'd0;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt = 1'b0;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_npc;
    logic        ifid_valid;
    logic        halted;

    int n_checks = 0;
    int n_err    = 0;

    fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload),
        .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall),
        .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .ifid_instr(ifid_instr), .ifid_npc(ifid_npc),
        .ifid_valid(ifid_valid), .halted(halted)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc     = 32'd0;
    logic [31:0] m_instr  = 32'd0;
    logic [31:0] m_npc    = 32'd0;
    logic        m_valid  = 1'b0;
    logic        m_halted = 1'b0;
    logic [63:0] skidq[$];

    always @(negedge nRST) begin
        m_pc = 32'd0; m_instr = 32'd0; m_npc = 32'd0; m_valid = 1'b0; m_halted = 1'b0;
        skidq.delete();
    end

    always @(posedge CLK) begin
        if (nRST && !m_halted) begin
            if (redirect) begin
                m_pc = redirect_pc & 32'hFFFF_FFFC;
                m_instr = 32'd0; m_valid = 1'b0;
                skidq.delete();
            end else if (halt) begin
                m_halted = 1'b1;
                m_instr = 32'd0; m_valid = 1'b0;
            end else begin
                if (skidq.size() == 0) begin
                    if (!stall) begin
                        if (ihit) begin
                            m_instr = iload; m_npc = m_pc + 32'd4; m_valid = 1'b1;
                            m_pc = m_pc + 32'd4;
                        end else begin
                            m_instr = 32'd0; m_valid = 1'b0;
                        end
                    end else if (SKID && ihit) begin
                        skidq.push_back({iload, m_pc + 32'd4});
                        m_pc = m_pc + 32'd4;
                    end
                end else if (!stall && !flush) begin
                    logic [63:0] e;
                    e = skidq.pop_front();
                    m_instr = e[63:32]; m_npc = e[31:0]; m_valid = 1'b1;
                end
                if (flush) begin
                    m_instr = 32'd0; m_valid = 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        logic exp_ren;
        #1;
        exp_ren = nRST && !m_halted && (skidq.size() == 0) && (SKID || !stall);
        chk("imemREN", {31'd0, imemREN}, {31'd0, exp_ren});
        chk("imemaddr", imemaddr, m_pc);
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
        chk("halted", {31'd0, halted}, {31'd0, m_halted});
        if (m_valid) chk("ifid_npc", ifid_npc, m_npc);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        ihit = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; halt = 1'b0;
    endtask

    initial begin
        int halt_cnt;
        // Reset values
        #3;
        chk("rst_ren", {31'd0, imemREN}, 32'd0);
        chk("rst_addr", imemaddr, 32'd0);
        chk("rst_instr", ifid_instr, 32'd0);
        chk("rst_npc", ifid_npc, 32'd0);
        chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        step(); step();

        // Sequential fetch
        nRST = 1'b1; ihit = 1'b1; iload = 32'h2401_0005;
        #1;
        chk("seq_ren", {31'd0, imemREN}, 32'd1);
        chk("seq_addr0", imemaddr, 32'd0);
        step();
        chk("seq_addr4", imemaddr, 32'd4);
        chk("seq_instr1", ifid_instr, 32'h2401_0005);
        chk("seq_npc1", ifid_npc, 32'd4);
        chk("seq_valid1", {31'd0, ifid_valid}, 32'd1);
        iload = 32'h2402_0003;
        step();
        chk("seq_addr8", imemaddr, 32'd8);
        chk("seq_instr2", ifid_instr, 32'h2402_0003);
        chk("seq_npc2", ifid_npc, 32'd8);

        // Stall for three cycles at pc=8
        stall = 1'b1; iload = 32'h2403_0001;
        #1;
        chk("stall_ren0", {31'd0, imemREN}, {31'd0, SKID});
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_addr", imemaddr, SKID ? 32'd12 : 32'd8);
            chk("stall_instr", ifid_instr, 32'h2402_0003);
            chk("stall_npc", ifid_npc, 32'd8);
            chk("stall_ren", {31'd0, imemREN}, 32'd0);
        end
        stall = 1'b0;
        step();
        chk("rel_instr", ifid_instr, 32'h2403_0001);
        chk("rel_npc", ifid_npc, 32'd12);
        chk("rel_valid", {31'd0, ifid_valid}, 32'd1);
        chk("rel_addr", imemaddr, 32'd12);

        // Redirect beats same-cycle ihit and halt
        redirect = 1'b1; redirect_pc = 32'h0000_0043; halt = 1'b1; ihit = 1'b1;
        step();
        chk("redir_addr", imemaddr, 32'h40);
        chk("redir_valid", {31'd0, ifid_valid}, 32'd0);
        chk("redir_halted", {31'd0, halted}, 32'd0);
        clr();

        // Flush under stall
        ihit = 1'b1; iload = 32'h8C22_0000;
        step();
        chk("pre_flush_valid", {31'd0, ifid_valid}, 32'd1);
        ihit = 1'b0; flush = 1'b1; stall = 1'b1;
        step();
        chk("flush_instr", ifid_instr, 32'd0);
        chk("flush_valid", {31'd0, ifid_valid}, 32'd0);
        chk("flush_addr", imemaddr, 32'h44);
        clr();

        // PC wrap, then async reset mid-fetch
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0; ihit = 1'b1; iload = 32'h0000_0020;
        step();
        chk("wrap_addr", imemaddr, 32'd0);
        chk("wrap_npc", ifid_npc, 32'd0);
        chk("wrap_instr", ifid_instr, 32'h0000_0020);
        #2;
        nRST = 1'b0;
        #1;
        chk("arst_ren", {31'd0, imemREN}, 32'd0);
        chk("arst_instr", ifid_instr, 32'd0);
        chk("arst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("arst_addr", imemaddr, 32'd0);
        step();
        nRST = 1'b1;

        // Halt is terminal until reset
        ihit = 1'b1; iload = 32'h2405_0007;
        step();
        halt = 1'b1;
        step();
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_addr", imemaddr, 32'd4);
        chk("halt_valid", {31'd0, ifid_valid}, 32'd0);
        halt = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        chk("halt_ren", {31'd0, imemREN}, 32'd0);
        step();
        chk("halt_frozen", imemaddr, 32'd4);
        chk("halt_stays", {31'd0, halted}, 32'd1);
        clr();
        nRST = 1'b0;
        #1;
        chk("halt_rst_addr", imemaddr, 32'd0);
        chk("halt_rst_halted", {31'd0, halted}, 32'd0);
        step();
        nRST = 1'b1;

        // Randomized traffic
        halt_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (m_halted) halt_cnt++;
            if (halt_cnt > 4) begin
                clr(); nRST = 1'b0; halt_cnt = 0;
                step();
                nRST = 1'b1;
            end else begin
                ihit     = ($urandom_range(0, 99) < 70);
                iload    = $urandom;
                stall    = ($urandom_range(0, 99) < 30);
                flush    = ($urandom_range(0, 99) < 10);
                redirect = ($urandom_range(0, 99) < 6);
                halt     = ($urandom_range(0, 199) < 2);
                redirect_pc = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
                step();
            end
        end
        clr();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
